multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Main control FSM of the multicycle MIPS-subset CPU.
- Sequences Fetch/Decode/Execute/Memory/Writeback per instruction from the IR opcode.
- Drives all datapath selects and enables, including ReadDst for the register read-address mux that sits directly downstream.
- Handshakes with the shared instruction/data memory via mem_ready.

Parameters:
- MEM_WAIT_EN, 1, when 1 memory states wait for mem_ready; when 0 mem_ready is treated as constant 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  6  IR[31:26], valid from DECODE onward.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory access complete this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if zero.
- iord  out  1  0 = PC address, 1 = ALUOut address.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  IR load.
- mem_to_reg  out  1  writeback source is MDR.
- pc_src  out  2  00 = ALU, 01 = ALUOut, 10 = jump target.
- alu_op  out  2  00 = add, 01 = sub, 10 = funct.
- alu_src_a  out  1  0 = PC, 1 = reg A.
- alu_src_b  out  2  00 = B, 01 = const 4, 10 = sext imm, 11 = sext imm << 2.
- reg_write  out  1  register file write enable.
- reg_dst  out  1  0 = rt, 1 = rd write address.
- read_dst  out  1  read-address mux select: 0 = rs field, 1 = rt field.
- illegal_op  out  1  sticky illegal-opcode flag.
- state_o  out  4  current state encoding, for debug.

Behaviour:
- Reset:
  - Async assert forces IDLE and clears illegal_op.
  - All other outputs are 0 while in IDLE.
  - Release is sampled on clk; IDLE always moves to FETCH on the next edge.
- Outputs are Moore, decoded from state only, except the mem_ready gating noted under FETCH.
- Unlisted outputs are 0 in every state.
- State encoding: IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, RTEXEC=7, RTWB=8, BRANCH=9, ADDIEX=10, ADDIWB=11, JUMP=12.
- FETCH:
  - mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
  - ir_write and pc_write = mem_ready; these are the only Mealy terms.
  - Go to DECODE when mem_ready=1, else stay.
- DECODE:
  - alu_src_a=0, alu_src_b=11, alu_op=00.
  - Next state by opcode: 000000 -> RTEXEC; 100011 or 101011 -> MEMADR; 000100 -> BRANCH; 001000 -> ADDIEX; 000010 -> JUMP.
  - Any other opcode -> FETCH and set illegal_op.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Go to MEMRD for lw, MEMWR for sw.
- MEMRD: mem_read=1, iord=1. Stay until mem_ready, then MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0. Go to FETCH.
- MEMWR:
  - mem_write=1, iord=1, read_dst=1.
  - Store data rt is re-read through the mux.
  - Stay until mem_ready, then FETCH.
  - mem_write is held for the entire wait.
- RTEXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Go to RTWB.
- RTWB: reg_write=1, reg_dst=1, mem_to_reg=0. Go to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_src=01. Go to FETCH; the zero-gated PC load happens externally.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00. Go to ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0. Go to FETCH.
- JUMP: pc_write=1, pc_src=10. Go to FETCH.
- read_dst is 0 in all states except MEMWR.
- Mutual exclusion: mem_read and mem_write are never both 1.
- illegal_op:
  - Sticky until reset.
  - A further illegal opcode leaves it at 1.
  - The CPU continues fetching after an illegal opcode.
- Unused state codes 13-15 go to FETCH on the next edge; all outputs are 0 while in them.
- Reset mid-wait (e.g. MEMRD with mem_ready=0): immediate IDLE, all outputs 0 in the same instant.
- Latency: R-type, addi and lw-without-wait take 4, 4 and 5 cycles respectively with mem_ready=1; sw takes 4, beq 3, j 3.

Decomposition:
- Shared package cpu_ctrl_pkg holds:
  - state enum/localparams;
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J;
  - pc_src, alu_op and alu_src_b encodings.
- Single module: next-state block plus output decode block.
- No sub-module; the output decode stays inline.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles, release -> state_o=0 for one edge, then 1; all outputs 0 during reset; ir_write=0 while mem_ready=0.
- R-type: opcode=000000, mem_ready=1 -> states 1,2,7,8,1; RTWB has reg_write=1 and reg_dst=1; read_dst=0 throughout.
- lw with 3 wait cycles in MEMRD: opcode=100011 -> MEMRD held 4 cycles with mem_read=1 and iord=1; MEMWB has mem_to_reg=1 and reg_write=1.
- sw: opcode=101011, mem_ready pulses after 2 cycles -> MEMWR held with mem_write=1 and read_dst=1; mem_read stays 0; then FETCH.
- beq/j/illegal:
  - beq -> BRANCH has pc_write_cond=1, alu_op=01, pc_src=01.
  - j -> JUMP has pc_write=1, pc_src=10.
  - opcode=111111 -> returns to FETCH after DECODE and illegal_op=1 sticks.
- Reset mid-MEMRD: assert rst_n=0 asynchronously -> state_o=0, mem_read=0 before the next clk edge, illegal_op cleared.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle CPU control FSM: state codes, opcodes
// and the datapath select encodings driven by the controller.
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_RTEXEC = 4'd7,
        S_RTWB   = 4'd8,
        S_BRANCH = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_JUMP   = 4'd12
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

endpackage

// File: rtl/multicycle_control_if.sv
// Control bundle between the FSM and the datapath/memory. Signals are plain
// level-valued; mem_ready qualifies the current memory access for one cycle.
interface multicycle_control_if;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic [1:0] pc_src;
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       reg_write;
    logic       reg_dst;
    logic       read_dst;
    logic       illegal_op;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
               mem_to_reg, pc_src, alu_op, alu_src_a, alu_src_b, reg_write,
               reg_dst, read_dst, illegal_op
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
               mem_to_reg, pc_src, alu_op, alu_src_a, alu_src_b, reg_write,
               reg_dst, read_dst, illegal_op
    );
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS-subset CPU. Outputs are decoded from
// the state register; only FETCH's ir_write/pc_write follow mem_ready directly.
module multicycle_control
    import cpu_ctrl_pkg::*;
#(
    parameter int MEM_WAIT_EN = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    multicycle_control_if.master bus,
    output logic [3:0]           state_o
);

    state_e state_q, state_d;
    logic   illegal_q, illegal_d;
    logic   mem_rdy;

    assign mem_rdy = (MEM_WAIT_EN != 0) ? bus.mem_ready : 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  if (mem_rdy) state_d = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_RTYPE:     state_d = S_RTEXEC;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        // Unknown opcode: flag it and keep the CPU fetching.
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR: state_d = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_rdy) state_d = S_MEMWB;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  if (mem_rdy) state_d = S_FETCH;
            S_RTEXEC: state_d = S_RTWB;
            S_RTWB:   state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_ADDIEX: state_d = S_ADDIWB;
            S_ADDIWB: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    always_comb begin
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.iord          = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.ir_write      = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.pc_src        = PCSRC_ALU;
        bus.alu_op        = ALUOP_ADD;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = SRCB_B;
        bus.reg_write     = 1'b0;
        bus.reg_dst       = 1'b0;
        bus.read_dst      = 1'b0;
        case (state_q)
            S_FETCH: begin
                bus.mem_read  = 1'b1;
                bus.alu_src_b = SRCB_FOUR;
                bus.ir_write  = mem_rdy;
                bus.pc_write  = mem_rdy;
            end
            S_DECODE: bus.alu_src_b = SRCB_IMM_SH;
            S_MEMADR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                bus.mem_read = 1'b1;
                bus.iord     = 1'b1;
            end
            S_MEMWB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                // rt is re-read through the read-address mux as store data.
                bus.mem_write = 1'b1;
                bus.iord      = 1'b1;
                bus.read_dst  = 1'b1;
            end
            S_RTEXEC: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = ALUOP_FUNCT;
            end
            S_RTWB: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                bus.alu_src_a     = 1'b1;
                bus.alu_op        = ALUOP_SUB;
                bus.pc_write_cond = 1'b1;
                bus.pc_src        = PCSRC_ALUOUT;
            end
            S_ADDIEX: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = SRCB_IMM;
            end
            S_ADDIWB: bus.reg_write = 1'b1;
            S_JUMP: begin
                bus.pc_write = 1'b1;
                bus.pc_src   = PCSRC_JUMP;
            end
            default: ;
        endcase
    end

    assign bus.illegal_op = illegal_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for the multicycle control FSM: each instruction is expanded
// into its expected per-cycle state trace and checked against an output table.
module tb_multicycle_control;
    import cpu_ctrl_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [3:0] state_o;

    multicycle_control_if bus ();

    multicycle_control #(.MEM_WAIT_EN(1)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .state_o (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected trace entries: {state[3:0], mem_ready, illegal_op}
    logic [5:0] exp_q[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    logic       m_ill   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [16:0] dut_outs();
        return {bus.pc_write, bus.pc_write_cond, bus.iord, bus.mem_read, bus.mem_write,
                bus.ir_write, bus.mem_to_reg, bus.pc_src, bus.alu_op, bus.alu_src_a,
                bus.alu_src_b, bus.reg_write, bus.reg_dst, bus.read_dst};
    endfunction

    // Output table written straight from the state descriptions.
    function automatic logic [16:0] exp_outs(input logic [3:0] st, input logic mr);
        logic       pcw, pcwc, iord, mrd, mwr, irw, m2r, asa, rw, rd, rdst;
        logic [1:0] pcs, aop, asb;
        {pcw, pcwc, iord, mrd, mwr, irw, m2r, asa, rw, rd, rdst} = '0;
        pcs = 2'b00; aop = 2'b00; asb = 2'b00;
        case (st)
            4'd1:  begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
            4'd2:  asb = 2'b11;
            4'd3:  begin asa = 1; asb = 2'b10; end
            4'd4:  begin mrd = 1; iord = 1; end
            4'd5:  begin rw = 1; m2r = 1; end
            4'd6:  begin mwr = 1; iord = 1; rdst = 1; end
            4'd7:  begin asa = 1; aop = 2'b10; end
            4'd8:  begin rw = 1; rd = 1; end
            4'd9:  begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
            4'd10: begin asa = 1; asb = 2'b10; end
            4'd11: rw = 1;
            4'd12: begin pcw = 1; pcs = 2'b10; end
            default: ;
        endcase
        return {pcw, pcwc, iord, mrd, mwr, irw, m2r, pcs, aop, asa, asb, rw, rd, rdst};
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [5:0] e;
            e = exp_q.pop_front();
            check("state", 32'(state_o), 32'(e[5:2]));
            check("outputs", 32'(dut_outs()), 32'(exp_outs(e[5:2], e[1])));
            check("illegal_op", 32'(bus.illegal_op), 32'(e[0]));
            check("rd_wr_mutex", 32'(bus.mem_read & bus.mem_write), 32'd0);
        end
    end

    task automatic step(input logic [3:0] st, input logic mr);
        exp_q.push_back({st, mr, m_ill});
        bus.mem_ready = mr;
        bus.zero      = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
    endtask

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    // Called at posedge+1, so the DUT already sits in the state about to be stepped.
    task automatic run_instr(input logic [5:0] op, input int fetch_wait, input int mem_wait);
        bus.opcode = op;
        repeat (fetch_wait) step(4'd1, 1'b0);
        step(4'd1, 1'b1);
        step(4'd2, rnd());
        case (op)
            OP_RTYPE: begin
                step(4'd7, rnd());
                check("rtwb_reg_write", 32'(bus.reg_write), 32'd1);
                check("rtwb_reg_dst", 32'(bus.reg_dst), 32'd1);
                step(4'd8, rnd());
            end
            OP_LW: begin
                step(4'd3, rnd());
                repeat (mem_wait) step(4'd4, 1'b0);
                step(4'd4, 1'b1);
                check("memwb_mem_to_reg", 32'(bus.mem_to_reg), 32'd1);
                check("memwb_reg_write", 32'(bus.reg_write), 32'd1);
                step(4'd5, rnd());
            end
            OP_SW: begin
                step(4'd3, rnd());
                check("sw_mem_write", 32'(bus.mem_write), 32'd1);
                check("sw_read_dst", 32'(bus.read_dst), 32'd1);
                check("sw_mem_read", 32'(bus.mem_read), 32'd0);
                repeat (mem_wait) step(4'd6, 1'b0);
                step(4'd6, 1'b1);
            end
            OP_BEQ: begin
                check("beq_pc_write_cond", 32'(bus.pc_write_cond), 32'd1);
                check("beq_alu_op", 32'(bus.alu_op), 32'h1);
                check("beq_pc_src", 32'(bus.pc_src), 32'h1);
                step(4'd9, rnd());
            end
            OP_ADDI: begin
                step(4'd10, rnd());
                step(4'd11, rnd());
            end
            OP_J: begin
                check("j_pc_write", 32'(bus.pc_write), 32'd1);
                check("j_pc_src", 32'(bus.pc_src), 32'h2);
                step(4'd12, rnd());
            end
            default: begin
                m_ill = 1'b1;
                check("illegal_back_to_fetch", 32'(state_o), 32'd1);
                check("illegal_flag_set", 32'(bus.illegal_op), 32'd1);
            end
        endcase
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        bus.opcode    = 6'd0;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.mem_ready = (i == 2);
            @(negedge clk);
            check("reset_state", 32'(state_o), 32'd0);
            check("reset_outputs", 32'(dut_outs()), 32'd0);
            check("reset_ir_write", 32'(bus.ir_write), 32'd0);
            check("reset_illegal", 32'(bus.illegal_op), 32'd0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(4'd0, 1'b0);

        run_instr(OP_RTYPE, 2, 0);
        run_instr(OP_LW, 0, 3);
        run_instr(OP_SW, 0, 2);
        run_instr(OP_BEQ, 0, 0);
        run_instr(OP_J, 1, 0);
        run_instr(OP_ADDI, 0, 0);
        run_instr(6'b111111, 0, 0);
        run_instr(OP_ADDI, 0, 0);
        run_instr(6'b101010, 0, 0);
        run_instr(OP_LW, 0, 0);
        run_instr(OP_RTYPE, 1, 0);

        // Asynchronous reset while MEMRD is stalled on mem_ready.
        bus.opcode = OP_LW;
        step(4'd1, 1'b1);
        step(4'd2, 1'b0);
        step(4'd3, 1'b0);
        step(4'd4, 1'b0);
        check("memrd_stalled_state", 32'(state_o), 32'd4);
        check("memrd_stalled_read", 32'(bus.mem_read), 32'd1);
        #5;
        rst_n = 1'b0;
        #1;
        check("async_rst_state", 32'(state_o), 32'd0);
        check("async_rst_mem_read", 32'(bus.mem_read), 32'd0);
        check("async_rst_iord", 32'(bus.iord), 32'd0);
        check("async_rst_illegal", 32'(bus.illegal_op), 32'd0);
        m_ill = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(4'd0, 1'b1);
        run_instr(OP_RTYPE, 0, 0);

        @(negedge clk);
        check("trace_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
